// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- double-buffered UART transmitter with runtime frame format.
//
// A one-entry holding register decouples the writer from the shifter, so a
// second word can be queued while the current frame is on the line. Each
// frame is: start bit (0), DATA_W data bits LSB first, an optional parity
// bit, then one or two stop bits (1). Every bit lasts OVERSAMPLE `en` ticks.
//
// Parameters
//   DATA_W      data bits per frame (5..9)
//   OVERSAMPLE  `en` ticks per bit period (>= 2)
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   data      word to send, captured on an accepted en_tx
//   en_tx     one-cycle write strobe
//   par_mode  00/11 none, 01 even, 10 odd; captured with data
//   stop2     0 = one stop bit, 1 = two; captured with data
//   en        one-cycle baud tick at OVERSAMPLE x baud rate
//   tbr       holding register empty (a write will be accepted)
//   tmt       holding register empty and shifter idle
//   ovr       one-cycle pulse, the cycle after a write was dropped
//   TxD       registered serial output, idles high

module uart_tx_cfg #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              en_tx,
    input  logic [1:0]        par_mode,
    input  logic              stop2,
    input  logic              en,
    output logic              tbr,
    output logic              tmt,
    output logic              ovr,
    output logic              TxD
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Holding register
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [1:0]        hold_par_q, hold_par_d;
    logic              hold_stop2_q, hold_stop2_d;
    logic              full_q, full_d;

    // Shifter
    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              stop_sec_q, stop_sec_d;   // second stop bit in progress
    logic [CNT_W-1:0]  tick_q, tick_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // Outputs
    logic              txd_q, txd_d;
    logic              ovr_q, ovr_d;

    logic              bit_end;
    logic              load;

    always_comb begin
        hold_data_d  = hold_data_q;
        hold_par_d   = hold_par_q;
        hold_stop2_d = hold_stop2_q;
        full_d       = full_q;
        state_d      = state_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        stop2_d      = stop2_q;
        stop_sec_d   = stop_sec_q;
        tick_d       = tick_q;
        idx_d        = idx_q;
        load         = 1'b0;

        // A write is dropped whenever the holding register is occupied before
        // the edge, even if the shifter empties it on that same edge.
        ovr_d   = en_tx & full_q;
        bit_end = en && (tick_q == TICK_LAST);

        if (en && (state_q != S_IDLE)) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (full_q) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        state_d    = par_en_q ? S_PARITY : S_STOP;
                        stop_sec_d = 1'b0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    stop_sec_d = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_sec_q) begin
                        stop_sec_d = 1'b1;
                    end else if (full_q) begin
                        // Queued word follows with no idle gap.
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            state_d    = S_START;
            shift_d    = hold_data_q;
            par_en_d   = (hold_par_q == 2'b01) || (hold_par_q == 2'b10);
            // Even parity is the XOR of the data; odd (10) inverts it, which
            // is exactly par_mode[1] for the two parity-enabled codes.
            par_bit_d  = (^hold_data_q) ^ hold_par_q[1];
            stop2_d    = hold_stop2_q;
            stop_sec_d = 1'b0;
            tick_d     = '0;
            idx_d      = '0;
            full_d     = 1'b0;
        end

        // Accept and load are mutually exclusive: load needs full_q=1,
        // accept needs full_q=0.
        if (en_tx && !full_q) begin
            hold_data_d  = data;
            hold_par_d   = par_mode;
            hold_stop2_d = stop2;
            full_d       = 1'b1;
        end

        // Line value follows the next state so TxD changes on the same edge
        // the FSM does, straight out of a flop.
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = par_bit_d;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data_q  <= '0;
            hold_par_q   <= '0;
            hold_stop2_q <= 1'b0;
            full_q       <= 1'b0;
            state_q      <= S_IDLE;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            stop2_q      <= 1'b0;
            stop_sec_q   <= 1'b0;
            tick_q       <= '0;
            idx_q        <= '0;
            txd_q        <= 1'b1;
            ovr_q        <= 1'b0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_par_q   <= hold_par_d;
            hold_stop2_q <= hold_stop2_d;
            full_q       <= full_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_bit_q    <= par_bit_d;
            stop2_q      <= stop2_d;
            stop_sec_q   <= stop_sec_d;
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            txd_q        <= txd_d;
            ovr_q        <= ovr_d;
        end
    end

    assign tbr = ~full_q;
    assign tmt = ~full_q & (state_q == S_IDLE);
    assign ovr = ovr_q;
    assign TxD = txd_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: a default 8-bit/16x instance and a narrow
// 5-bit/4x instance. Fixed frames come from a vector table, multi-cycle
// corners from hand sequences, and a random phase is checked every cycle
// against a line model that expands each frame into per-tick samples.

module tb_uart_tx_cfg;

    localparam int DW  = 8;
    localparam int OS  = 16;
    localparam int DW2 = 5;
    localparam int OS2 = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [DW-1:0]  data = '0;
    logic           en_tx = 1'b0;
    logic [1:0]     par_mode = 2'b00;
    logic           stop2 = 1'b0;
    logic           en = 1'b0;
    logic           tbr, tmt, ovr, txd;

    logic [DW2-1:0] data2 = '0;
    logic           en_tx2 = 1'b0;
    logic [1:0]     par2 = 2'b00;
    logic           stop2_2 = 1'b0;
    logic           en2 = 1'b0;
    logic           tbr2, tmt2, ovr2, txd2;

    int errors = 0;
    int checks = 0;

    bit en_rand  = 1'b0;
    int en_div   = 6;
    int en_cnt   = 0;
    int en2_gap  = 1;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_W(DW), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .data(data), .en_tx(en_tx), .par_mode(par_mode),
        .stop2(stop2), .en(en), .tbr(tbr), .tmt(tmt), .ovr(ovr), .TxD(txd)
    );

    uart_tx_cfg #(.DATA_W(DW2), .OVERSAMPLE(OS2)) dut_n (
        .clk(clk), .rst(rst), .data(data2), .en_tx(en_tx2), .par_mode(par2),
        .stop2(stop2_2), .en(en2), .tbr(tbr2), .tmt(tmt2), .ovr(ovr2), .TxD(txd2)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // One step: land 2 ns after the falling edge. Ticks are driven at +1,
    // stimulus and sequence sampling at +2, the line model at +4.
    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    // Main baud tick: fixed divider or random.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (en_rand) begin
                en = ($urandom_range(0, 2) == 0);
            end else begin
                en     = (en_cnt >= en_div - 1);
                en_cnt = (en_cnt >= en_div - 1) ? 0 : en_cnt + 1;
            end
        end
    end

    // Narrow-instance tick with random gaps of 1..10 clk.
    initial begin
        forever begin
            en2_gap = $urandom_range(1, 10);
            repeat (en2_gap - 1) begin
                @(negedge clk);
                #1;
                en2 = 1'b0;
            end
            @(negedge clk);
            #1;
            en2 = 1'b1;
        end
    end

    // ---------------- line model (main instance) ----------------
    // m_line holds the expected TxD value for every remaining `en` tick of
    // the frame in flight; one tick consumes one entry.
    logic       m_line[$];
    bit         m_full = 1'b0;
    logic [7:0] m_d = '0;
    logic [1:0] m_p = '0;
    logic       m_s = 1'b0;
    logic       m_ovr = 1'b0;

    task automatic push_frame(input logic [7:0] d, input logic [1:0] p, input logic s);
        logic bits[$];
        int   ones;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            bits.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (p == 2'b01) bits.push_back((ones % 2) == 1);
        if (p == 2'b10) bits.push_back((ones % 2) == 0);
        bits.push_back(1'b1);
        if (s) bits.push_back(1'b1);
        foreach (bits[i]) begin
            repeat (OS) m_line.push_back(bits[i]);
        end
    endtask

    initial begin
        logic [3:0] exp;
        bit         pre;
        forever begin
            @(negedge clk);
            #4;
            if (model_on) begin
                exp = {(m_line.size() > 0) ? m_line[0] : 1'b1, !m_full,
                       !m_full && (m_line.size() == 0), m_ovr};
                chkn("line_model{txd,tbr,tmt,ovr}", 32'({txd, tbr, tmt, ovr}), 32'(exp));
            end
            if (rst) begin
                m_line.delete();
                m_full = 1'b0;
                m_ovr  = 1'b0;
            end else begin
                pre   = m_full;
                m_ovr = en_tx && pre;
                if (en && (m_line.size() > 0)) void'(m_line.pop_front());
                if ((m_line.size() == 0) && pre) begin
                    push_frame(m_d, m_p, m_s);
                    m_full = 1'b0;
                end
                if (en_tx && !pre) begin
                    m_d    = data;
                    m_p    = par_mode;
                    m_s    = stop2;
                    m_full = 1'b1;
                end
            end
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic write(input logic [7:0] d, input logic [1:0] p, input logic s);
        data     = d;
        par_mode = p;
        stop2    = s;
        en_tx    = 1'b1;
        cyc();
        en_tx    = 1'b0;
    endtask

    task automatic next_en(input int k);
        for (int i = 0; i < k; i++) begin
            cyc();
            while (!en) cyc();
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (tmt === 1'b1 && tbr === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: transmitter never went idle, want tmt=1", name);
        end
    endtask

    // Finds the first tick of a start bit (checking the current cycle
    // first), then samples each bit in the middle of its period.
    task automatic capture(input string name, input int len, output logic [11:0] bits);
        bit ok;
        ok   = 1'b0;
        bits = '0;
        for (int c = 0; c < 20000; c++) begin
            if (en && txd === 1'b0) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: no start bit seen, want one", name);
        end else begin
            next_en(OS / 2 - 1);
            bits[0] = txd;
            for (int i = 1; i < len; i++) begin
                next_en(OS);
                bits[i] = txd;
            end
        end
    endtask

    typedef struct {
        string       name;
        logic [7:0]  d;
        logic [1:0]  p;
        logic        s;
        int          len;
        logic [11:0] exp;   // bit i = i-th bit on the line
    } vec_t;

    vec_t tbl[5];

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish in time");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        logic [11:0] got;
        logic [7:0]  nexp;
        int          run;
        int          tmt_hi;
        bit          seen;
        bit          ok;

        tbl[0] = '{"frame_8n1_e3",    8'hE3, 2'b00, 1'b0, 10, {2'b00, 1'b1, 8'hE3, 1'b0}};
        tbl[1] = '{"frame_even_e3",   8'hE3, 2'b01, 1'b0, 11, {1'b0, 1'b1, 1'b1, 8'hE3, 1'b0}};
        tbl[2] = '{"frame_odd_e3",    8'hE3, 2'b10, 1'b0, 11, {1'b0, 1'b1, 1'b0, 8'hE3, 1'b0}};
        tbl[3] = '{"frame_8n2_55_m3", 8'h55, 2'b11, 1'b1, 11, {1'b0, 2'b11, 8'h55, 1'b0}};
        tbl[4] = '{"frame_8n1_a5",    8'hA5, 2'b00, 1'b0, 10, {2'b00, 1'b1, 8'hA5, 1'b0}};

        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk1("rst_txd", txd, 1'b1);
        chk1("rst_tbr", tbr, 1'b1);
        chk1("rst_tmt", tmt, 1'b1);
        chk1("rst_ovr", ovr, 1'b0);
        chk1("rst_n_txd", txd2, 1'b1);
        chk1("rst_n_tbr", tbr2, 1'b1);
        chk1("rst_n_tmt", tmt2, 1'b1);
        chk1("rst_n_ovr", ovr2, 1'b0);
        model_on = 1'b1;

        // ---- table-driven frames ----
        for (int i = 0; i < 5; i++) begin
            wait_idle({tbl[i].name, "_idle"});
            write(tbl[i].d, tbl[i].p, tbl[i].s);
            if (i == 0) begin
                chk1("tbr_after_write", tbr, 1'b0);
                cyc();
                chk1("tbr_after_load", tbr, 1'b1);
                chk1("txd_after_load", txd, 1'b0);
                chk1("tmt_after_load", tmt, 1'b0);
            end
            capture(tbl[i].name, tbl[i].len, got);
            chkn(tbl[i].name, 32'(got), 32'(tbl[i].exp));
            if (i == 0) begin
                next_en(OS / 2);
                chk1("tmt_at_tick160", tmt, 1'b0);
                cyc();
                chk1("tmt_after_tick160", tmt, 1'b1);
            end
        end

        // ---- back-to-back with two stop bits ----
        wait_idle("b2b_idle");
        write(8'h55, 2'b00, 1'b1);
        cyc();
        chk1("b2b_tbr_first_load", tbr, 1'b1);
        next_en(20);
        write(8'hAA, 2'b00, 1'b0);
        chk1("b2b_tbr_held", tbr, 1'b0);
        run = 0;
        tmt_hi = 0;
        seen = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (tmt !== 1'b0) tmt_hi++;
            if (tbr === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (en) run = (txd === 1'b1) ? run + 1 : 0;
            cyc();
        end
        chk1("b2b_second_load", seen, 1'b1);
        chkn("b2b_high_ticks", 32'(run), 32'd32);
        chkn("b2b_tmt_low", 32'(tmt_hi), 32'd0);
        chk1("b2b_second_start", txd, 1'b0);

        // ---- overrun: writes every other cycle, aligned just after a tick ----
        wait_idle("ovr_idle");
        while (!en) cyc();
        write(8'h11, 2'b00, 1'b0);
        cyc();
        write(8'h22, 2'b00, 1'b0);
        chk1("ovr_tbr_22_held", tbr, 1'b0);
        cyc();
        write(8'h33, 2'b00, 1'b0);
        chk1("ovr_pulse", ovr, 1'b1);
        cyc();
        chk1("ovr_one_cycle", ovr, 1'b0);
        capture("ovr_frame_11", 10, got);
        chkn("ovr_frame_11", 32'(got), 32'({1'b1, 8'h11, 1'b0}));
        capture("ovr_frame_22", 10, got);
        chkn("ovr_frame_22", 32'(got), 32'({1'b1, 8'h22, 1'b0}));
        wait_idle("ovr_drain");
        repeat (200) cyc();
        chk1("ovr_no_third_frame", tmt, 1'b1);

        // ---- reset mid-frame, with a word queued ----
        write(8'hC3, 2'b00, 1'b0);
        capture("rstmf_start", 1, got);
        write(8'h77, 2'b00, 1'b0);
        next_en(OS * 4 - 1);          // middle of data bit 3 (a 0 for 0xC3)
        chk1("rstmf_txd_before", txd, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk1("rstmf_txd", txd, 1'b1);
        chk1("rstmf_tbr", tbr, 1'b1);
        chk1("rstmf_tmt", tmt, 1'b1);
        chk1("rstmf_ovr", ovr, 1'b0);
        repeat (3) cyc();
        write(8'hA5, 2'b00, 1'b0);
        capture("rstmf_a5", 10, got);
        chkn("rstmf_a5", 32'(got), 32'({1'b1, 8'hA5, 1'b0}));

        // ---- random traffic against the line model ----
        wait_idle("rand_idle");
        en_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                              : int'($urandom_range(20, 400));
            repeat (run) cyc();
            write(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        wait_idle("rand_drain");
        en_rand = 1'b0;

        // ---- narrow instance: 5 data bits, 4x, odd parity, random gaps ----
        nexp = 8'b1011_1110;          // 0,1,1,1,1,1,0,1 on the line
        data2   = 5'h1F;
        par2    = 2'b10;
        stop2_2 = 1'b0;
        en_tx2  = 1'b1;
        cyc();
        en_tx2  = 1'b0;
        chk1("n_tbr_after_write", tbr2, 1'b0);
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (en2 && txd2 === 1'b0) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        chk1("n_start_seen", ok, 1'b1);
        for (int k = 0; k < 8 * OS2; k++) begin
            chk1($sformatf("n_tick%0d", k), txd2, nexp[k / OS2]);
            cyc();
            while (!en2) cyc();
        end
        chk1("n_idle_txd", txd2, 1'b1);
        chk1("n_idle_tmt", tmt2, 1'b1);
        chk1("n_idle_ovr", ovr2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
